// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write signals of the program loader.
// The loader takes the slave modport. The host/bench side takes the master modport.
interface imem_loader_if;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic        wr_en_imem_o;
  logic [31:0] wr_instr_imem_o;
  logic [31:0] addr_imem_o;

  modport slave (
    input  byte_valid_i, byte_data_i,
    output byte_ready_o, wr_en_imem_o, wr_instr_imem_o, addr_imem_o
  );

  modport master (
    output byte_valid_i, byte_data_i,
    input  byte_ready_o, wr_en_imem_o, wr_instr_imem_o, addr_imem_o
  );
endinterface

// File: rtl/imem_loader.sv
// Program image loader. It parses a big-endian byte stream made of a 16-bit
// word count followed by the words. It writes each word into instruction
// memory and keeps the CPU in reset until the whole image is written.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,  // must be 4-byte aligned
  parameter int unsigned MAX_WORDS = 1024            // must be <= 65535
) (
  input  logic               clk,
  input  logic               reset,          // asynchronous, active low
  input  logic               start_i,
  imem_loader_if.slave       bus,
  output logic               cpu_hold_o,
  output logic               done_o,
  output logic               error_o,
  output logic [15:0]        words_loaded_o
);

  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERROR
  } state_t;

  localparam logic [15:0] MAX_W = MAX_WORDS[15:0];

  state_t      state_q, state_d;
  logic [15:0] n_q, n_d;           // word count from the header
  logic [23:0] asm_q, asm_d;       // first three bytes of the word being assembled
  logic [1:0]  idx_q, idx_d;       // byte position within the current word
  logic        wr_en_q, wr_en_d;
  logic [31:0] word_q, word_d;
  logic [31:0] addr_q, addr_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [15:0] cnt_q, cnt_d;

  logic        ready;
  logic        take;
  logic [15:0] n_full;
  logic [15:0] cnt_inc;

  assign ready   = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA);
  assign take    = bus.byte_valid_i && ready;
  assign n_full  = {n_q[15:8], bus.byte_data_i};
  assign cnt_inc = cnt_q + 16'd1;

  // Next-state and registered-output logic of the load sequencer
  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
    state_d = state_q;
    n_d     = n_q;
    asm_d   = asm_q;
    idx_d   = idx_q;
    wr_en_d = 1'b0;
    word_d  = word_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    done_d  = done_q;
    error_d = error_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_LEN_HI: begin
        if (take) begin
          n_d[15:8] = bus.byte_data_i;
          state_d   = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (take) begin
          n_d[7:0] = bus.byte_data_i;
          if (n_full == 16'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else if (n_full > MAX_W) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (take) begin
          idx_d = idx_q + 2'd1;
          asm_d = {asm_q[15:0], bus.byte_data_i};
          if (idx_q == 2'd3) begin
            state_d = S_WRITE;
            wr_en_d = 1'b1;
            word_d  = {asm_q, bus.byte_data_i};
            addr_d  = BASE_ADDR + {14'd0, cnt_q, 2'b00};
          end
        end
      end
      S_WRITE: begin
        cnt_d = cnt_inc;
        if (cnt_inc == n_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          hold_d  = 1'b0;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DONE: begin
        if (start_i) begin
          state_d = S_LEN_HI;
          done_d  = 1'b0;
          hold_d  = 1'b1;
          cnt_d   = 16'd0;
          idx_d   = 2'd0;
        end
      end
      S_ERROR: begin
        if (start_i) begin
          state_d = S_LEN_HI;
          error_d = 1'b0;
          cnt_d   = 16'd0;
          idx_d   = 2'd0;
        end
      end
      default: state_d = S_LEN_HI;
    endcase
  end

  // State and output registers; reset abandons any load in progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_LEN_HI;
      n_q     <= '0;
      asm_q   <= '0;
      idx_q   <= '0;
      wr_en_q <= 1'b0;
      word_q  <= '0;
      addr_q  <= BASE_ADDR;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the pre-edge values.
      state_q <= state_d;
      n_q     <= n_d;
      asm_q   <= asm_d;
      idx_q   <= idx_d;
      wr_en_q <= wr_en_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      error_q <= error_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.byte_ready_o    = ready;
  assign bus.wr_en_imem_o    = wr_en_q;
  assign bus.wr_instr_imem_o = word_q;
  assign bus.addr_imem_o     = addr_q;
  assign cpu_hold_o          = hold_q;
  assign done_o              = done_q;
  assign error_o             = error_q;
  assign words_loaded_o      = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader. Two instances share one byte stream.
// Instance A uses base address 0x0 and instance B uses base address 0x400.
// The stimulus pushes the expected writes into a queue for each instance.
// A monitor pops and compares an entry on every write pulse.
module tb_imem_loader;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       valid;
  logic [7:0] data;

  logic        hold_a, done_a, err_a, hold_b, done_b, err_b;
  logic [15:0] words_a, words_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] exp_a[$];
  logic [63:0] exp_b[$];
  logic [63:0] e_a, e_b;

  imem_loader_if if_a ();
  imem_loader_if if_b ();

  assign if_a.byte_valid_i = valid;
  assign if_a.byte_data_i  = data;
  assign if_b.byte_valid_i = valid;
  assign if_b.byte_data_i  = data;

  imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(1024)) dut_a (
    .clk(clk), .reset(reset), .start_i(start), .bus(if_a),
    .cpu_hold_o(hold_a), .done_o(done_a), .error_o(err_a), .words_loaded_o(words_a)
  );

  imem_loader #(.BASE_ADDR(32'h0000_0400), .MAX_WORDS(1024)) dut_b (
    .clk(clk), .reset(reset), .start_i(start), .bus(if_b),
    .cpu_hold_o(hold_b), .done_o(done_b), .error_o(err_b), .words_loaded_o(words_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write
  always @(negedge clk) begin
    if (if_a.wr_en_imem_o === 1'b1) begin
      if (exp_a.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL a_unexpected_write: got addr %h data %h, expected no write",
                 if_a.addr_imem_o, if_a.wr_instr_imem_o);
      end else begin
        e_a = exp_a.pop_front();
        check("a_write_addr", if_a.addr_imem_o, e_a[63:32]);
        check("a_write_data", if_a.wr_instr_imem_o, e_a[31:0]);
      end
    end
    if (if_b.wr_en_imem_o === 1'b1) begin
      if (exp_b.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL b_unexpected_write: got addr %h data %h, expected no write",
                 if_b.addr_imem_o, if_b.wr_instr_imem_o);
      end else begin
        e_b = exp_b.pop_front();
        check("b_write_addr", if_b.addr_imem_o, e_b[63:32]);
        check("b_write_data", if_b.wr_instr_imem_o, e_b[31:0]);
      end
    end
  end

  // Offer one byte from a negedge and hold it until it is accepted.
  // With gap set, insert one idle cycle afterwards.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    valid = 1'b1;
    data  = b;
    while (if_a.byte_ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_cmp++; n_err++;
      $display("FAIL byte_accept_timeout: got ready low for %0d cycles, expected acceptance", n);
    end
    @(negedge clk);
    valid = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int idx, input bit gap);
    exp_a.push_back({32'h0000_0000 + 32'(4 * idx), w});
    exp_b.push_back({32'h0000_0400 + 32'(4 * idx), w});
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8],  gap);
    send_byte(w[7:0],   gap);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_a !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_done(input string tag, input logic [15:0] words);
    check({tag, "_done_a"},  done_a, 1'b1);
    check({tag, "_hold_a"},  hold_a, 1'b0);
    check({tag, "_words_a"}, words_a, words);
    check({tag, "_ready_a"}, if_a.byte_ready_o, 1'b0);
    check({tag, "_error_a"}, err_a, 1'b0);
    check({tag, "_done_b"},  done_b, 1'b1);
    check({tag, "_words_b"}, words_b, words);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic two_word_image(input bit gap);
    send_byte(8'h00, gap);
    send_byte(8'h02, gap);
    send_word(32'h2401_0005, 0, gap);
    send_word(32'h0000_000C, 1, gap);
    wait_done();
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    valid = 1'b0;
    data  = 8'h00;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_ready",  if_a.byte_ready_o, 1'b1);
    check("rst_hold",   hold_a, 1'b1);
    check("rst_wr_en",  if_a.wr_en_imem_o, 1'b0);
    check("rst_instr",  if_a.wr_instr_imem_o, 32'h0);
    check("rst_addr_a", if_a.addr_imem_o, 32'h0);
    check("rst_addr_b", if_b.addr_imem_o, 32'h400);
    check("rst_done",   done_a, 1'b0);
    check("rst_error",  err_a, 1'b0);
    check("rst_words",  words_a, 16'd0);
    reset = 1'b1;
    @(negedge clk);

    // Two-word image, back-to-back bytes
    two_word_image(1'b0);
    check_done("img1", 16'd2);

    // Reload with a bubble after every byte
    pulse_start();
    check("reload_done_drop", done_a, 1'b0);
    check("reload_hold_rise", hold_a, 1'b1);
    check("reload_words_clr", words_a, 16'd0);
    two_word_image(1'b1);
    check_done("img2", 16'd2);

    // Empty image: done follows the header with no writes
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    @(negedge clk);
    check_done("empty", 16'd0);

    // Oversized header is rejected; reload recovers
    pulse_start();
    send_byte(8'h04, 1'b0);
    send_byte(8'h01, 1'b0);
    repeat (2) @(negedge clk);
    check("err_error", err_a, 1'b1);
    check("err_hold",  hold_a, 1'b1);
    check("err_ready", if_a.byte_ready_o, 1'b0);
    check("err_done",  done_a, 1'b0);
    check("err_error_b", err_b, 1'b1);
    pulse_start();
    check("err_clear", err_a, 1'b0);
    check("err_ready_again", if_a.byte_ready_o, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_word(32'hDEAD_BEEF, 0, 1'b0);
    wait_done();
    check_done("after_err", 16'd1);

    // Start with a byte already offered: the byte is not taken while in DONE
    start = 1'b1;
    valid = 1'b1;
    data  = 8'h00;
    @(negedge clk);
    start = 1'b0;
    check("start_done_drop", done_a, 1'b0);
    check("start_hold_rise", hold_a, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_word(32'h1122_3344, 0, 1'b0);
    wait_done();
    check_done("one_word", 16'd1);

    // Reset in the middle of a word, then a fresh full load
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    reset = 1'b0;
    #1;
    check("mid_rst_ready", if_a.byte_ready_o, 1'b1);
    check("mid_rst_hold",  hold_a, 1'b1);
    check("mid_rst_instr", if_a.wr_instr_imem_o, 32'h0);
    check("mid_rst_addr",  if_a.addr_imem_o, 32'h0);
    check("mid_rst_words", words_a, 16'd0);
    check("mid_rst_done",  done_a, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    two_word_image(1'b1);
    check_done("post_rst", 16'd2);

    repeat (3) @(negedge clk);
    check("queue_a_empty", exp_a.size(), 32'd0);
    check("queue_b_empty", exp_b.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end
endmodule
